// File: rtl/floo_mask_pkg.sv
// Shared types for the multicast mask-rule lookup: rule/entry structs and default sizes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package floo_mask_pkg;

  localparam int unsigned DefaultNumReq       = 4;
  localparam int unsigned DefaultNumMaskRules = 8;
  localparam int unsigned IdWidth             = 8;
  localparam int unsigned MaskWidth           = 4;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [MaskWidth-1:0] mask_sel_t;

  typedef struct packed {
    id_t       id;
    mask_sel_t mask_x;
    mask_sel_t mask_y;
  } mask_rule_t;

  typedef struct packed {
    mask_rule_t rule;
    logic       valid;
  } mask_entry_t;

  // Index width with a floor of one bit so single-entry configurations still have a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_mask_rr_arb.sv
// Round-robin arbiter: one-hot grant plus encoded winner index, pointer advances past the winner.
// Latency: combinational grant; pointer updates on the clock edge of an accepted grant.
// Backpressure: en low suppresses all grants and freezes the pointer.
//
// Ports: clk/rst_n (async active-low), en (downstream can accept), req (per-requester valid),
//        gnt (one-hot grant, gated by en), idx (winner index), any (at least one request).
module floo_mask_rr_arb
  import floo_mask_pkg::*;
#(
  parameter int unsigned NumReq = DefaultNumReq,
  localparam int unsigned IdxW  = idx_width(NumReq)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;

  // Scan from the pointer upward with wrap; the first asserted request wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      cand = IdxW'((32'(ptr_q) + 32'(off)) % NumReq);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && any) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en && any) begin
      ptr_q <= (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/floo_mask_lookup_arb.sv
// Shared multicast mask-rule lookup: arbitrates requesters, decodes the winning ID against a programmable table.
// Latency: exactly 1 cycle from accept to rsp_valid_o; 1 lookup/cycle when rsp_ready_i stays high.
// Backpressure: a held response (rsp_valid_o && !rsp_ready_i) blocks all req_ready_o; cfg writes never stall.
//
// Ports: clk_i/rst_ni (async active-low); req_valid_i/req_ready_o/req_id_i per requester;
//        rsp_valid_o/rsp_ready_i/rsp_idx_o/rsp_mask_x_o/rsp_mask_y_o/rsp_dec_error_o response channel;
//        cfg_we_i/cfg_idx_i/cfg_en_i/cfg_rule_i table write port.
module floo_mask_lookup_arb
  import floo_mask_pkg::*;
#(
  parameter int unsigned NumReq       = DefaultNumReq,
  parameter int unsigned NumMaskRules = DefaultNumMaskRules,
  localparam int unsigned IdxW        = idx_width(NumReq),
  localparam int unsigned CfgW        = idx_width(NumMaskRules)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  id_t  [NumReq-1:0]      req_id_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IdxW-1:0]        rsp_idx_o,
  output mask_sel_t              rsp_mask_x_o,
  output mask_sel_t              rsp_mask_y_o,
  output logic                   rsp_dec_error_o,
  input  logic                   cfg_we_i,
  input  logic [CfgW-1:0]        cfg_idx_i,
  input  logic                   cfg_en_i,
  input  mask_rule_t             cfg_rule_i
);

  mask_entry_t tbl_q [NumMaskRules];

  logic            accept_en;
  logic            accept;
  logic            arb_any;
  logic [IdxW-1:0] arb_idx;
  id_t             lk_id;
  logic            hit;
  mask_rule_t      hit_rule;

  assign accept_en = !rsp_valid_o || rsp_ready_i;
  assign accept    = accept_en && arb_any;

  floo_mask_rr_arb #(
    .NumReq (NumReq)
  ) i_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (accept_en),
    .req   (req_valid_i),
    .gnt   (req_ready_o),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Ascending scan with overwrite, so the highest matching valid entry wins.
  always_comb begin
    lk_id    = req_id_i[arb_idx];
    hit      = 1'b0;
    hit_rule = '0;
    for (int i = 0; i < int'(NumMaskRules); i++) begin
      if (tbl_q[i].valid && (tbl_q[i].rule.id == lk_id)) begin
        hit      = 1'b1;
        hit_rule = tbl_q[i].rule;
      end
    end
  end

  // Table write lands at the edge, so a lookup in the same cycle still sees the old contents.
  // Indices beyond the table match no entry and are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumMaskRules); i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NumMaskRules); i++) begin
        if (cfg_we_i && (32'(cfg_idx_i) == 32'(i))) begin
          tbl_q[i].rule  <= cfg_rule_i;
          tbl_q[i].valid <= cfg_en_i;
        end
      end
    end
  end

  // Payload only loads on accept, so it stays stable while the response is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o     <= 1'b0;
      rsp_idx_o       <= '0;
      rsp_mask_x_o    <= '0;
      rsp_mask_y_o    <= '0;
      rsp_dec_error_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o     <= 1'b1;
      rsp_idx_o       <= arb_idx;
      rsp_mask_x_o    <= hit_rule.mask_x;
      rsp_mask_y_o    <= hit_rule.mask_y;
      rsp_dec_error_o <= !hit;
    end else if (rsp_ready_i) begin
      rsp_valid_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_floo_mask_lookup_arb.sv
// Self-checking bench for floo_mask_lookup_arb: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model compared every cycle.
// Model: table as arrays, round-robin as a wrap-around scan, response as a single slot.
module tb_floo_mask_lookup_arb;
  import floo_mask_pkg::*;

  localparam int N = 4;
  localparam int R = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  id_t  [N-1:0] req_id;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_idx;
  mask_sel_t    rsp_x;
  mask_sel_t    rsp_y;
  logic         rsp_err;
  logic         cfg_we;
  logic [2:0]   cfg_idx;
  logic         cfg_en;
  mask_rule_t   cfg_rule;

  floo_mask_lookup_arb #(.NumReq(N), .NumMaskRules(R)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_id_i        (req_id),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_idx_o       (rsp_idx),
    .rsp_mask_x_o    (rsp_x),
    .rsp_mask_y_o    (rsp_y),
    .rsp_dec_error_o (rsp_err),
    .cfg_we_i        (cfg_we),
    .cfg_idx_i       (cfg_idx),
    .cfg_en_i        (cfg_en),
    .cfg_rule_i      (cfg_rule)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mt_vld [R];
  int mt_id  [R];
  int mt_x   [R];
  int mt_y   [R];
  int m_ptr, m_idx, m_x, m_y, m_w;
  bit m_vld, m_err, m_en;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Highest valid matching entry, found by scanning downward.
  task automatic model_lookup(input int id, output int x, output int y, output bit err);
    x = 0; y = 0; err = 1'b1;
    for (int i = R - 1; i >= 0; i--) begin
      if (mt_vld[i] && mt_id[i] == id) begin
        x = mt_x[i]; y = mt_y[i]; err = 1'b0;
        return;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < R; i++) begin
        mt_vld[i] = 1'b0; mt_id[i] = 0; mt_x[i] = 0; mt_y[i] = 0;
      end
      m_ptr = 0; m_vld = 1'b0; m_idx = 0; m_x = 0; m_y = 0; m_err = 1'b0;
    end else begin
      m_en = !m_vld || rsp_ready;
      m_w  = rr_pick(m_ptr, req_valid);
      if (m_en && m_w >= 0) begin
        model_lookup(int'(req_id[m_w]), m_x, m_y, m_err);
        m_idx = m_w;
        m_vld = 1'b1;
        m_ptr = (m_w + 1) % N;
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
      if (cfg_we && int'(cfg_idx) < R) begin
        mt_vld[cfg_idx] = cfg_en;
        mt_id[cfg_idx]  = int'(cfg_rule.id);
        mt_x[cfg_idx]   = int'(cfg_rule.mask_x);
        mt_y[cfg_idx]   = int'(cfg_rule.mask_y);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] c_rdy;
  int           c_w;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      c_rdy = '0;
      c_w   = rr_pick(m_ptr, req_valid);
      if ((!m_vld || rsp_ready) && c_w >= 0) c_rdy[c_w] = 1'b1;
      check("mdl_req_ready", req_ready, c_rdy);
      check("mdl_rsp_valid", rsp_valid, m_vld);
      if (m_vld) begin
        check("mdl_rsp_idx", rsp_idx, m_idx);
        check("mdl_rsp_x", rsp_x, m_x);
        check("mdl_rsp_y", rsp_y, m_y);
        check("mdl_rsp_err", rsp_err, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int id, input int x, input int y, input bit en);
    cfg_we          = 1'b1;
    cfg_idx         = 3'(idx);
    cfg_rule.id     = id_t'(id);
    cfg_rule.mask_x = mask_sel_t'(x);
    cfg_rule.mask_y = mask_sel_t'(y);
    cfg_en          = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lookup_chk(input string nm, input int r, input int id,
                            input int ex, input int ey, input bit eerr);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_id[r]    = id_t'(id);
    tick();
    req_valid = '0;
    @(negedge clk);
    check({nm, "_vld"}, rsp_valid, 1);
    check({nm, "_idx"}, rsp_idx, r);
    check({nm, "_x"}, rsp_x, ex);
    check({nm, "_y"}, rsp_y, ey);
    check({nm, "_err"}, rsp_err, eerr);
    tick();
  endtask

  initial begin
    req_valid = '0;
    req_id    = '0;
    rsp_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_en    = 1'b0;
    cfg_rule  = '0;
    chk_on    = 1'b1;

    // Reset state.
    #7;
    check("rst_valid", rsp_valid, 0);
    check("rst_idx", rsp_idx, 0);
    check("rst_x", rsp_x, 0);
    check("rst_y", rsp_y, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ready", req_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic hit, priority of highest index, invalidation, miss.
    cfg_write(0, 5, 'h3, 'h1, 1'b1);
    lookup_chk("hit", 2, 5, 'h3, 'h1, 1'b0);
    cfg_write(3, 5, 'hF, 'h2, 1'b1);
    lookup_chk("prio", 0, 5, 'hF, 'h2, 1'b0);
    cfg_write(3, 5, 'hF, 'h2, 1'b0);
    lookup_chk("inval", 1, 5, 'h3, 'h1, 1'b0);
    lookup_chk("miss", 2, 9, 0, 0, 1'b1);

    // Reset clears the table: id 0 must miss.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    lookup_chk("zero", 3, 0, 0, 0, 1'b1);

    // All requesters valid: grants cycle 0,1,2,3,0 with one response per cycle.
    for (int r = 0; r < N; r++) req_id[r] = id_t'(r + 20);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_gnt", req_ready, 4'b0001 << (k % N));
      if (k > 0) begin
        check("rr_vld", rsp_valid, 1);
        check("rr_idx", rsp_idx, (k - 1) % N);
      end
      tick();
    end

    // Stall: nobody is granted and the held response does not move.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_gnt", req_ready, 0);
      check("hold_vld", rsp_valid, 1);
      check("hold_idx", rsp_idx, 0);
      check("hold_err", rsp_err, 1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_gnt", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();

    // Write and lookup in the same cycle: old table for this lookup, new one from the next.
    cfg_we          = 1'b1;
    cfg_idx         = 3'd1;
    cfg_en          = 1'b1;
    cfg_rule.id     = id_t'(7);
    cfg_rule.mask_x = 4'h5;
    cfg_rule.mask_y = 4'h6;
    req_valid       = 4'b0001;
    req_id[0]       = id_t'(7);
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("same_cyc_err", rsp_err, 1);
    check("same_cyc_vld", rsp_valid, 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("next_cyc_err", rsp_err, 0);
    check("next_cyc_x", rsp_x, 'h5);
    check("next_cyc_y", rsp_y, 'h6);

    // Asynchronous reset drops a pending response immediately.
    #2;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("async_rst_vld", rsp_valid, 0);
    tick(); tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();

    // Randomized traffic against the model, with one mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) req_id[r] = id_t'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_idx   = 3'($urandom_range(0, R - 1));
      cfg_en    = ($urandom_range(0, 3) != 0);
      cfg_rule.id     = id_t'($urandom_range(0, 7));
      cfg_rule.mask_x = mask_sel_t'($urandom);
      cfg_rule.mask_y = mask_sel_t'($urandom);
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1502) rst_n = 1'b1;
      tick();
    end
    req_valid = '0;
    cfg_we    = 1'b0;
    rsp_ready = 1'b1;
    tick(); tick();
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floo_mask_lookup_arb.md
Name: floo_mask_lookup_arb

Overview:
- Shares one multicast mask-rule lookup between NumReq requesters, for example the per-port multicast handlers of a router.
- Owns a run-time-programmable mask rule table.
- Round-robin arbitrates lookup requests, decodes the winning ID against the table, and returns x/y masks plus a decode error on one registered response channel.
- Sits between the router/chimney multicast logic and the system configuration port.

Parameters:
- NumReq, 4, number of lookup requesters (≥1).
- NumMaskRules, 8, number of table entries (≥1).
- id_t, logic, node ID type.
- mask_sel_t, logic, x/y mask type.
- mask_rule_t, logic, struct {id, mask_x, mask_y}, defined in the shared package.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  per-requester lookup valid.
- req_ready_o  out  NumReq  per-requester grant/accept.
- req_id_i  in  NumReq x id_t  ID to look up.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_idx_o  out  $clog2(NumReq) (min 1)  index of the requester the response belongs to.
- rsp_mask_x_o  out  mask_sel_t  decoded x mask.
- rsp_mask_y_o  out  mask_sel_t  decoded y mask.
- rsp_dec_error_o  out  1  no valid rule matched.
- cfg_we_i  in  1  table write strobe.
- cfg_idx_i  in  $clog2(NumMaskRules) (min 1)  entry to write.
- cfg_en_i  in  1  entry valid bit to store.
- cfg_rule_i  in  mask_rule_t  rule to store.

Behaviour:
- Reset (async, rst_ni=0):
  - all table entries zero and invalid;
  - rsp_valid_o=0, rsp_idx_o=0, rsp_mask_x_o=0, rsp_mask_y_o=0, rsp_dec_error_o=0;
  - round-robin pointer=0;
  - req_ready_o follows the combinational rule below (it can be nonzero in reset only if req_valid_i is asserted).
- Table:
  - On cfg_we_i, entry[cfg_idx_i] is set to {cfg_rule_i, cfg_en_i} at the clock edge.
  - cfg_idx_i ≥ NumMaskRules is ignored (no write).
  - Writes are always accepted; there is no backpressure.
- Lookup:
  - Only entries with the valid bit set participate.
  - If several match, the highest index wins.
  - No match gives dec_error=1 and masks=0.
- Pipeline:
  - One output register stage; latency is exactly 1 cycle from accept to rsp_valid_o.
  - Stage can accept when accept_en = !rsp_valid_o || rsp_ready_i.
  - Throughput is 1 lookup/cycle under continuous rsp_ready_i.
- Arbitration:
  - Round robin among asserted req_valid_i, starting at the pointer.
  - req_ready_o is one-hot, asserted only for the winner and only when accept_en.
  - req_ready_o may depend combinationally on req_valid_i.
  - No other requester sees ready.
  - On accept, pointer = (winner+1) mod NumReq. Pointer holds when there is no accept.
- Response hold:
  - While rsp_valid_o && !rsp_ready_i, all rsp_* outputs are stable.
  - rsp_valid_o deasserts after a handshake unless a new request is accepted in the same cycle.
- Simultaneous config write and lookup in the same cycle:
  - The lookup uses the table contents from before the write.
  - The new contents are visible to lookups accepted from the next cycle.
- A config write to an entry does not alter a response already in the output register.
- NumReq=1: the arbiter degenerates to pass-through and rsp_idx_o=0.
- Mid-operation reset drops any pending response; the table is invalidated.

Decomposition:
- Package floo_mask_pkg holds:
  - the mask_rule_t struct template;
  - a table entry struct {rule, valid};
  - default widths for NumReq and NumMaskRules.
- Sub-module floo_mask_rr_arb:
  - N-way round-robin grant with pointer register and enable input;
  - one-hot grant output plus encoded index.
- Table storage, match loop and output register stay in the top module.

Test Plan:
- Program entry0={id=5,x=0x3,y=0x1,en=1}; requester 2 sends id=5 -> next cycle rsp_valid=1, idx=2, x=0x3, y=0x1, err=0.
- Entry0 and entry3 both id=5, with entry3 {x=0xF,y=0x2} -> lookup id=5 returns x=0xF, y=0x2. Invalidate entry3 (en=0) -> returns entry0 masks.
- Lookup id=9 with no matching valid entry -> err=1, x=0, y=0. Same lookup after reset with an all-zero table and id=0 -> err=1.
- All 4 requesters valid continuously with rsp_ready_i=1 -> grants in order 0,1,2,3,0. One response/cycle, rsp_idx_o matches.
- Hold rsp_ready_i=0 for 3 cycles with pending requests -> req_ready_o all 0 and rsp_* stable. Release -> next grant follows the round-robin order.
- Same cycle: cfg_we_i writes entry1 id=7 while id=7 is accepted -> err=1. Id=7 accepted the next cycle -> hit. Assert rst_ni=0 mid-response -> rsp_valid_o=0 immediately.
